// File: rtl/param_dot_pe.sv
`default_nettype none
// ============================================================================
// Module   : param_dot_pe
// Purpose  : LANES-wide signed dot-product PE that accumulates beats into
//            groups framed by first/last flags. The psum update saturates when
//            PARAM_DOT_PE_SAT_EN is defined; otherwise it wraps.
// Revision : 1.0 - initial release
// ============================================================================
module param_dot_pe #(
    parameter int LANES = 32,
    parameter int DW    = 16,
    parameter int ACC_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [LANES*DW-1:0] neuron,
    input  logic [LANES*DW-1:0] weight,
    input  logic [1:0]          ctl,
    input  logic                vld_i,
    output logic                rdy_o,
    output logic [ACC_W-1:0]    result,
    output logic [15:0]         beats,
    output logic                vld_o,
    input  logic                rdy_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_n;
    logic                      r_s1_vld;
    logic                      r_s1_first;
    logic                      r_s1_last;
    logic signed [ACC_W-1:0]   r_s1_dot;
    logic signed [ACC_W-1:0]   r_psum;
    logic [15:0]               r_cnt;
    logic [ACC_W-1:0]          r_result;
    logic [15:0]               r_beats;

    logic signed [2*DW-1:0]    w_prod;
    logic signed [ACC_W-1:0]   w_dot;
    logic                      w_start;
    logic signed [ACC_W-1:0]   w_sum;
    logic signed [ACC_W-1:0]   w_psum_upd;
    logic [15:0]               w_cnt_upd;
    logic signed [ACC_W-1:0]   w_psum_n;
    logic [15:0]               w_cnt_n;
    logic [ACC_W-1:0]          w_result_n;
    logic [15:0]               w_beats_n;

    assign vld_o  = (r_state == OUT);
    assign rdy_o  = !vld_o || rdy_i;
    assign result = r_result;
    assign beats  = r_beats;

    // Each product is exact in 2*DW bits; sign-extension into the sum keeps
    // the dot product at full precision.
    always_comb begin
        w_dot  = '0;
        w_prod = '0;
        for (int i = 0; i < LANES; i++) begin
            w_prod = (2*DW)'($signed(neuron[i*DW +: DW])) *
                     (2*DW)'($signed(weight[i*DW +: DW]));
            w_dot  = w_dot + ACC_W'(w_prod);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld   <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_dot   <= '0;
        end else if (rdy_o) begin
            r_s1_vld   <= vld_i;
            r_s1_first <= ctl[0];
            r_s1_last  <= ctl[1];
            r_s1_dot   <= w_dot;
        end
    end

`ifdef PARAM_DOT_PE_SAT_EN
    logic signed [ACC_W:0] w_wide;

    always_comb begin
        w_wide = (ACC_W+1)'(r_psum) + (ACC_W+1)'(r_s1_dot);
        if (w_wide[ACC_W] != w_wide[ACC_W-1]) begin
            w_sum = w_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                  : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            w_sum = w_wide[ACC_W-1:0];
        end
    end
`else
    assign w_sum = r_psum + r_s1_dot;
`endif

    // Any beat that does not continue an open group starts a new one.
    assign w_start    = r_s1_first || (r_state != ACC);
    assign w_psum_upd = w_start ? r_s1_dot : w_sum;
    assign w_cnt_upd  = w_start ? 16'd1
                      : ((r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1);

    always_comb begin
        w_state_n  = r_state;
        w_psum_n   = r_psum;
        w_cnt_n    = r_cnt;
        w_result_n = r_result;
        w_beats_n  = r_beats;
        if (rdy_o) begin
            if (r_state == OUT) begin
                w_state_n = IDLE;
            end
            if (r_s1_vld) begin
                w_psum_n = w_psum_upd;
                w_cnt_n  = w_cnt_upd;
                if (r_s1_last) begin
                    w_state_n  = OUT;
                    w_result_n = w_psum_upd;
                    w_beats_n  = w_cnt_upd;
                end else begin
                    w_state_n  = ACC;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_psum   <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_beats  <= '0;
        end else begin
            r_state  <= w_state_n;
            r_psum   <= w_psum_n;
            r_cnt    <= w_cnt_n;
            r_result <= w_result_n;
            r_beats  <= w_beats_n;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_param_dot_pe.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_dot_pe
// Purpose  : Scoreboard bench for param_dot_pe (LANES=4, DW=8) with a second
//            ACC_W=16 instance for the overflow case (PARAM_DOT_PE_SAT_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_dot_pe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] neuron, weight;
    logic [1:0]  ctl;
    logic        vld_i, rdy_o, vld_o, rdy_i;
    logic [31:0] result;
    logic [15:0] beats;

    logic [31:0] n16, w16;
    logic [1:0]  ctl16;
    logic        vld16, rdy16_o, vo16, rdy16_i;
    logic [15:0] res16;
    logic [15:0] beats16;

    always #5 clk = ~clk;

    param_dot_pe #(.LANES(4), .DW(8), .ACC_W(32)) u_dut (
        .clk(clk), .rst(rst), .neuron(neuron), .weight(weight), .ctl(ctl),
        .vld_i(vld_i), .rdy_o(rdy_o), .result(result), .beats(beats),
        .vld_o(vld_o), .rdy_i(rdy_i)
    );

    param_dot_pe #(.LANES(4), .DW(8), .ACC_W(16)) u_dut16 (
        .clk(clk), .rst(rst), .neuron(n16), .weight(w16), .ctl(ctl16),
        .vld_i(vld16), .rdy_o(rdy16_o), .result(res16), .beats(beats16),
        .vld_o(vo16), .rdy_i(rdy16_i)
    );

`ifdef PARAM_DOT_PE_SAT_EN
    localparam longint EXP16 = 32767;
`else
    localparam longint EXP16 = -25536;
`endif

    typedef struct {
        longint res;
        longint bts;
    } exp_t;

    exp_t   q[$];
    int     checks   = 0;
    int     failures = 0;
    bit     rand_rdy = 1'b0;
    bit     m_open   = 1'b0;
    longint m_psum   = 0;
    longint m_cnt    = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    function automatic longint mdot(input logic [31:0] n, input logic [31:0] w);
        byte    a, b;
        longint s;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            a = n[i*8 +: 8];
            b = w[i*8 +: 8];
            s += longint'(a) * longint'(b);
        end
        return s;
    endfunction

    // Bring a mathematical value into the signed range of a w-bit accumulator.
    function automatic longint fit(input longint v, input int w);
        longint lo, hi, m;
        lo = -(64'sd1 <<< (w-1));
        hi = (64'sd1 <<< (w-1)) - 1;
`ifdef PARAM_DOT_PE_SAT_EN
        m = (v > hi) ? hi : ((v < lo) ? lo : v);
`else
        m = v & ((64'sd1 <<< w) - 1);
        if (m > hi) m -= (64'sd1 <<< w);
`endif
        return m;
    endfunction

    task automatic model_accept(input logic [31:0] n, input logic [31:0] w, input logic [1:0] c);
        longint d;
        exp_t   e;
        d = mdot(n, w);
        if (c[0] || !m_open) begin
            m_psum = fit(d, 32);
            m_cnt  = 1;
        end else begin
            m_psum = fit(m_psum + d, 32);
            m_cnt  = (m_cnt < 65535) ? m_cnt + 1 : 65535;
        end
        if (c[1]) begin
            e.res = m_psum;
            e.bts = m_cnt;
            q.push_back(e);
            m_open = 1'b0;
        end else begin
            m_open = 1'b1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_rdy) rdy_i = ($urandom_range(0, 3) != 0);
    endtask

    task automatic beat(input logic [31:0] n, input logic [31:0] w, input logic [1:0] c, output int waited);
        neuron = n; weight = w; ctl = c; vld_i = 1'b1;
        waited = 0;
        forever begin
            @(negedge clk);
            if (rdy_o) break;
            waited++;
            if (waited > 200) break;
            step();
        end
        if (waited > 200) begin
            chk("beat_accept_timeout", waited, 0);
        end else begin
            model_accept(n, w, c);
        end
        step();
        vld_i = 1'b0;
    endtask

    task automatic idle(input int k);
        vld_i = 1'b0;
        repeat (k) step();
    endtask

    initial begin
        int         wt;
        int         k;
        logic [1:0] c;
        logic [31:0] ones;

        neuron = '0; weight = '0; ctl = '0; vld_i = 1'b0; rdy_i = 1'b1;
        n16 = '0; w16 = '0; ctl16 = '0; vld16 = 1'b0; rdy16_i = 1'b1;
        ones = 32'h0101_0101;

        fork
            forever begin
                @(negedge clk);
                if (!rst && vld_o) begin
                    if (q.size() == 0) begin
                        chk("unexpected_vld_o", longint'(vld_o), 0);
                    end else begin
                        chk("result", longint'($signed(result)), q[0].res);
                        chk("beats", longint'(beats), q[0].bts);
                        if (rdy_i) void'(q.pop_front());
                    end
                end
            end
        join_none

        // Reset values
        @(negedge clk);
        chk("rst_vld_o", vld_o, 0);
        chk("rst_result", result, 0);
        chk("rst_beats", beats, 0);
        chk("rst_rdy_o", rdy_o, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        step();

        // Single beat group, lanes {1,2,3,4} x {5,6,7,8}, 2-cycle latency
        beat(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 2'b11, wt);
        chk("lat_cycle1_vld_o", vld_o, 0);
        step();
        chk("lat_cycle2_vld_o", vld_o, 1);
        chk("lat_result70", longint'($signed(result)), 70);
        idle(3);

        // Three beats of all-ones lanes, no backpressure
        beat(ones, ones, 2'b01, wt); chk("no_stall_b1", wt, 0);
        beat(ones, ones, 2'b00, wt); chk("no_stall_b2", wt, 0);
        beat(ones, ones, 2'b10, wt); chk("no_stall_b3", wt, 0);
        idle(4);

        // Output stall: rdy_i low for 5 cycles with a pending beat
        rdy_i = 1'b0;
        beat(pack4(2, 0, 0, 0), pack4(3, 0, 0, 0), 2'b11, wt);
        for (k = 0; k < 10 && !vld_o; k++) step();
        chk("stall_vld_o_seen", vld_o, 1);
        neuron = pack4(4, 4, 0, 0); weight = pack4(1, 1, 0, 0); ctl = 2'b11; vld_i = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("stall_rdy_o", rdy_o, 0);
            chk("stall_vld_o", vld_o, 1);
            step();
        end
        rdy_i = 1'b1;
        beat(pack4(4, 4, 0, 0), pack4(1, 1, 0, 0), 2'b11, wt);
        idle(4);

        // Restart mid-group: 50+50 discarded, then 0 (first) + 7 (last)
        beat(pack4(5, 5, 0, 0), pack4(5, 5, 0, 0), 2'b01, wt);
        beat(pack4(5, 5, 0, 0), pack4(5, 5, 0, 0), 2'b00, wt);
        beat(pack4(0, 0, 0, 0), pack4(9, 9, 9, 9), 2'b01, wt);
        beat(pack4(7, 0, 0, 0), pack4(1, 0, 0, 0), 2'b10, wt);
        idle(4);

        // Reset during beat 2 of a 3-beat group
        beat(pack4(10, 0, 0, 0), pack4(10, 0, 0, 0), 2'b01, wt);
        neuron = pack4(20, 0, 0, 0); weight = pack4(1, 0, 0, 0); ctl = 2'b00; vld_i = 1'b1;
        rst = 1'b1;
        m_open = 1'b0;
        q.delete();
        @(negedge clk);
        chk("rst_mid_vld_o", vld_o, 0);
        @(posedge clk);
        #1 rst = 1'b0; vld_i = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_vld_o", vld_o, 0);
            step();
        end
        beat(pack4(3, 0, 0, 0), pack4(3, 0, 0, 0), 2'b00, wt);
        beat(pack4(1, 1, 0, 0), pack4(2, 2, 0, 0), 2'b10, wt);
        idle(4);

        // Randomised traffic with random backpressure
        rand_rdy = 1'b1;
        for (int r = 0; r < 300; r++) begin
            c[0] = ($urandom_range(0, 5) == 0);
            c[1] = ($urandom_range(0, 3) == 0);
            beat($urandom, $urandom, c, wt);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        rand_rdy = 1'b0;
        rdy_i = 1'b1;
        vld_i = 1'b0;
        for (k = 0; k < 200 && q.size() != 0; k++) step();
        chk("drain_pending", q.size(), 0);
        idle(5);

        // ACC_W=16 instance: two beats of +20000
        step();
        n16 = pack4(100, 100, 0, 0); w16 = pack4(100, 100, 0, 0);
        ctl16 = 2'b01; vld16 = 1'b1;
        @(negedge clk);
        chk("acc16_rdy_b1", rdy16_o, 1);
        step();
        ctl16 = 2'b10;
        @(negedge clk);
        chk("acc16_rdy_b2", rdy16_o, 1);
        step();
        vld16 = 1'b0;
        for (k = 0; k < 10 && !vo16; k++) @(negedge clk);
        chk("acc16_vld_o", vo16, 1);
        chk("acc16_result", longint'($signed(res16)), EXP16);
        chk("acc16_beats", beats16, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/param_dot_pe.md
PARAM_DOT_PE -- requirements
Module: param_dot_pe

Interface
REQ-001 SHALL provide parameter LANES, default 32, number of parallel multiply lanes (power of 2, 2..64).
REQ-002 SHALL provide parameter DW, default 16, signed operand width per lane.
REQ-003 SHALL provide parameter ACC_W, default 32, signed accumulator and result width (ACC_W >= 2*DW+log2(LANES)).
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 neuron  input  LANES*DW  packed signed operands, lane i at bits [i*DW +: DW].
REQ-007 weight  input  LANES*DW  packed signed operands, same lane packing.
REQ-008 ctl  input  2  ctl[0]=first beat of group, ctl[1]=last beat of group.
REQ-009 vld_i  input  1  input beat valid.
REQ-010 rdy_o  output  1  block accepts beat this cycle.
REQ-011 result  output  ACC_W  signed group dot-product.
REQ-012 beats  output  16  beat count of the emitted group.
REQ-013 vld_o  output  1  result/beats valid.
REQ-014 rdy_i  input  1  downstream accepts result.

Function
REQ-015 Beat SHALL be accepted when vld_i && rdy_o; rdy_o = !vld_o || rdy_i (combinational), and the whole pipeline SHALL advance only when rdy_o = 1.
REQ-016 Stage 1 SHALL register the signed sum of LANES signed DW x DW products, full precision, plus first/last flags and a valid bit.
REQ-017 Stage 2 SHALL update psum: first -> psum = sign-extended dot; else psum = psum + dot.
REQ-018 States: IDLE (no open group), ACC (group open), OUT (vld_o held).
REQ-019 IDLE: stage-2 beat without first SHALL be treated as first; goes to ACC, or to OUT if last.
REQ-020 ACC: beat with first SHALL discard partial psum and restart count at 1; beat with last goes to OUT.
REQ-021 Beat with first and last together SHALL form a single-beat group.
REQ-022 On group close, result SHALL take the final psum and beats the group's beat count, and vld_o SHALL rise; latency is 2 cycles from accepting the last beat to vld_o, absent stall.
REQ-023 OUT: result, beats and vld_o SHALL stay stable until rdy_i = 1; on handshake go to IDLE, or to OUT again if stage 2 closes another group in the same cycle.
REQ-024 Beat counter SHALL saturate at 16'hFFFF.
REQ-025 Cycles with vld_i = 0 SHALL leave psum and count unchanged (no implicit clear).

Reset
REQ-026 Asserting rst SHALL immediately clear: state = IDLE, stage-1 valid, psum, count, result = 0, beats = 0, vld_o = 0.
REQ-027 rst mid-group SHALL discard the partial group; no result SHALL be emitted for it.

Configuration
REQ-028 Macro PARAM_DOT_PE_SAT_EN defined: psum update SHALL saturate to signed ACC_W range [-2^(ACC_W-1), 2^(ACC_W-1)-1]; undefined: SHALL wrap modulo 2^ACC_W.

Verification
REQ-029 LANES=4, DW=8: one beat, neuron lanes {1,2,3,4}, weight {5,6,7,8}, ctl=2'b11 -> 2 cycles later vld_o=1, result=70, beats=1.
REQ-030 Three beats (ctl 01, 00, 10), each lane product 1 on 4 lanes -> result=12, beats=3; rdy_o remains 1 with rdy_i=1.
REQ-031 Hold rdy_i=0 for 5 cycles after vld_o -> result stable, rdy_o=0, no beat accepted; rdy_i=1 -> next group proceeds intact.
REQ-032 Mid-group beat with ctl=01 after two beats summing 100, then beat dot=7 with ctl=10 -> result=7, beats=2.
REQ-033 ACC_W=16, repeated dot=+20000 beats: with PARAM_DOT_PE_SAT_EN -> result=32767; without -> wrapped value (2 beats: -25536).
REQ-034 Assert rst during beat 2 of a 3-beat group -> vld_o stays 0; next group's result excludes all pre-reset beats.
